uart_regif: RTL and testbench
=============================

# uart_regif

UART core with a 32-bit data-register interface: the responder that the LED command handler and other register-bus clients use to send and receive bytes. It serialises written bytes onto `ser_tx` as 8N1 frames and deserialises `ser_rx` into a small receive FIFO. Reads return the oldest received byte, or all-ones when the FIFO is empty. `reg_dat_wait` stalls writers while a frame is in flight. It sits between the top-level command state machine and the board UART pins, and runs on the 12 MHz hardware oscillator.

## Interface
- `DIV`, 1250: clock cycles per bit; 1250 gives 9600 baud at 12 MHz. Legal range is 16..65535.
- `RX_DEPTH`, 4: receive FIFO entries; must be a power of 2, at least 2.
- `hw_clk` in 1: the only clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `ser_tx` out 1: serial output; idles high.
- `ser_rx` in 1: serial input; asynchronous.
- `reg_dat_we` in 1: write strobe; bits [7:0] of `reg_dat_di` are transmitted.
- `reg_dat_re` in 1: read strobe; pops the FIFO head.
- `reg_dat_di` in 32: write data; bits [31:8] are ignored.
- `reg_dat_do` out 32: read data, `{24'h0, head}` when non-empty, `32'hFFFF_FFFF` when empty.
- `reg_dat_wait` out 1: the write is not accepted this cycle.
- `rx_overrun` out 1: sticky flag set when a received byte is dropped because the FIFO is full.

## Operation
- Reset values:
  - `ser_tx` = 1, `rx_overrun` = 0.
  - FIFO empty, so `reg_dat_do` = `32'hFFFF_FFFF`.
  - TX and RX state machines in IDLE; RX synchroniser flops = 1.
- Combinational outputs:
  - `reg_dat_wait` = `reg_dat_we & tx_busy`.
  - `reg_dat_do` is a combinational function of the FIFO head and occupancy count.
- TX state machine, IDLE → SHIFT → IDLE:
  - A write is accepted in any cycle with `reg_dat_we` = 1 and `tx_busy` = 0. The byte is latched into a 10-bit shifter `{1, byte, 0}`.
  - In SHIFT, each bit is held on `ser_tx` for exactly DIV cycles: start bit (0), then data LSB first, then stop bit (1).
  - A 16-bit bit timer counts 0..DIV-1. A 4-bit index counts 0..9.
  - Writes that are not accepted have no side effects. The writer holds `reg_dat_we` and `reg_dat_di` until `reg_dat_wait` drops.
- RX state machine:
  - `ser_rx` passes through a 2-flop synchroniser.
  - IDLE: a synchronised 0 goes to START.
  - START: wait DIV/2 cycles (integer division), then resample. 0 goes to DATA; 1 is a false start and returns to IDLE.
  - DATA: sample every DIV cycles, 8 samples, shifted in LSB first, then go to STOP.
  - STOP: sample after DIV cycles.
    - Sample 1 (valid stop): push the byte and go to IDLE.
    - Sample 0 (framing error): discard the byte and go to WAITHI.
  - WAITHI: stay until the synchronised line is 1, then go to IDLE.
- FIFO: `RX_DEPTH` entries, with pointers and a count of width log2(`RX_DEPTH`)+1. Pointers wrap modulo `RX_DEPTH`.
  - `reg_dat_re` when the FIFO is empty has no effect.
  - A push while full drops the new byte, sets `rx_overrun`, and leaves the FIFO contents unchanged.
  - Push and pop in the same cycle while full: the pop takes effect, the push is stored, and the count is unchanged. No overrun.
  - Push and `reg_dat_re` in the same cycle while empty: the read is ignored, because `reg_dat_do` was all-ones that cycle. The byte is stored and the count becomes 1.
- Reset asserted mid-operation:
  - Any TX frame aborts; `ser_tx` is 1 from the next edge.
  - Any RX frame is abandoned, the FIFO empties, and `rx_overrun` clears.

## Timing
- TX latency:
  - A write accepted at edge N puts the start bit on `ser_tx` from N+1.
  - The stop bit ends at N+1+10·DIV.
  - `tx_busy` is high over cycles N+1 .. N+10·DIV.
  - A write held from cycle N+1 is accepted at cycle N+10·DIV+1. Back-to-back frames have no idle gap.
- RX latency:
  - Let F be the first cycle the raw line reads 0.
  - The byte is visible on `reg_dat_do` at F + 2 + DIV/2 + 9·DIV + 1, ±1 cycle.
- A pop at edge N shows the next entry (or all-ones) on `reg_dat_do` from N+1.
- Sampling error: a sender may differ from nominal baud by ±2% and still be received correctly.

## Test plan
- Reset, then check idle outputs:
  - `reg_dat_do` = FFFFFFFF, `ser_tx` = 1, `reg_dat_wait` = 0 when `we` = 0.
  - With `reg_dat_re` pulsed, the outputs stay the same.
- Single TX:
  - Stimulus: DIV = 16, write 0x50 ("P").
  - `ser_tx` carries 0,0,0,0,0,1,0,1,0,1, each for 16 cycles, starting one cycle after accept.
  - A second write held during the frame sees `reg_dat_wait` = 1 for 160 cycles and is then accepted with no gap.
- Single RX:
  - Stimulus: drive the 8N1 frame for 0x31 ("1") at DIV = 16.
  - `reg_dat_do` = 0x00000031 within the stated latency.
  - `reg_dat_re` for 1 cycle returns `reg_dat_do` to FFFFFFFF.
- RX overrun:
  - Stimulus: RX_DEPTH = 4, receive 0x30..0x34 with no reads.
  - `rx_overrun` = 1.
  - Four reads return 0x30, 0x31, 0x32, 0x33, then FFFFFFFF.
- RX line errors:
  - A 4-cycle low glitch produces no byte.
  - A frame with stop bit 0 pushes nothing.
  - Holding the line low afterwards produces no spurious start until the line returns high.
- Reset mid-frame:
  - Stimulus: assert `reset` during TX bit 4 and during RX data bit 3.
  - `ser_tx` = 1 the next cycle, FIFO empty, and a subsequent clean frame is received correctly.

Source files
------------

// File: rtl/uart_regif.sv
// UART responder behind a 32-bit data register: 8N1 transmit shifter,
// oversampled receiver and a small receive FIFO with a sticky overrun flag.
module uart_regif #(
  parameter int unsigned DIV      = 1250,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic        hw_clk,
  input  logic        reset,
  output logic        ser_tx,
  input  logic        ser_rx,
  input  logic        reg_dat_we,
  input  logic        reg_dat_re,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait,
  output logic        rx_overrun
);

  localparam int unsigned AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = 16;
  localparam logic [TW-1:0] BIT_LAST  = TW'(DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(RX_DEPTH);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;

  // ---------------------------------------------------------------- transmit
  tx_state_t     tx_state, tx_state_nxt;
  logic [9:0]    tx_shift;
  logic [TW-1:0] tx_timer;
  logic [3:0]    tx_idx;
  logic          tx_busy, tx_accept_c, tx_bit_end_c;
  logic          unused_di_c;

  assign unused_di_c = ^reg_dat_di[31:8];

  always_ff @(posedge hw_clk) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_accept_c) tx_state_nxt = TX_SHIFT;
      TX_SHIFT: if (tx_bit_end_c && tx_idx == 4'd9) tx_state_nxt = TX_IDLE;
      default:  tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_busy      = (tx_state == TX_SHIFT);
    tx_accept_c  = reg_dat_we & ~tx_busy;
    tx_bit_end_c = tx_busy && (tx_timer == BIT_LAST);
    reg_dat_wait = reg_dat_we & tx_busy;
  end

  // ser_tx is loaded one bit ahead so each bit appears right at its boundary
  always_ff @(posedge hw_clk) begin
    if (reset) begin
      ser_tx   <= 1'b1;
      tx_shift <= '1;
      tx_timer <= '0;
      tx_idx   <= '0;
    end else if (tx_accept_c) begin
      ser_tx   <= 1'b0;
      tx_shift <= {1'b1, reg_dat_di[7:0], 1'b0};
      tx_timer <= '0;
      tx_idx   <= '0;
    end else if (tx_busy) begin
      if (tx_bit_end_c) begin
        tx_timer <= '0;
        tx_idx   <= tx_idx + 4'd1;
        tx_shift <= {1'b1, tx_shift[9:1]};
        ser_tx   <= (tx_idx == 4'd9) ? 1'b1 : tx_shift[1];
      end else begin
        tx_timer <= tx_timer + TW'(1);
      end
    end
  end

  // ----------------------------------------------------------------- receive
  rx_state_t     rx_state, rx_state_nxt;
  logic          rx_s1, rx_s2;
  logic [TW-1:0] rx_timer;
  logic [2:0]    rx_cnt;
  logic [7:0]    rx_byte;
  logic          rx_half_c, rx_full_c, rx_sample_c, rx_push_c;

  always_ff @(posedge hw_clk) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= ser_rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge hw_clk) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE:   if (!rx_s2) rx_state_nxt = RX_START;
      RX_START:  if (rx_half_c) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_full_c && rx_cnt == 3'd7) rx_state_nxt = RX_STOP;
      RX_STOP:   if (rx_full_c) rx_state_nxt = rx_s2 ? RX_IDLE : RX_WAITHI;
      RX_WAITHI: if (rx_s2) rx_state_nxt = RX_IDLE;
      default:   rx_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_half_c   = (rx_timer == HALF_LAST);
    rx_full_c   = (rx_timer == BIT_LAST);
    rx_sample_c = (rx_state == RX_DATA) && rx_full_c;
    rx_push_c   = (rx_state == RX_STOP) && rx_full_c && rx_s2;
  end

  // Bit timer restarts on every state change and every data sample
  always_ff @(posedge hw_clk) begin
    if (reset) begin
      rx_timer <= '0;
      rx_cnt   <= '0;
      rx_byte  <= '0;
    end else begin
      if (rx_state == RX_IDLE || rx_state == RX_WAITHI ||
          rx_state_nxt != rx_state || rx_full_c)
        rx_timer <= '0;
      else
        rx_timer <= rx_timer + TW'(1);
      if (rx_state == RX_START)
        rx_cnt <= '0;
      else if (rx_sample_c)
        rx_cnt <= rx_cnt + 3'd1;
      if (rx_sample_c)
        rx_byte <= {rx_s2, rx_byte[7:1]};
    end
  end

  // -------------------------------------------------------------------- fifo
  logic [7:0]    rx_mem [RX_DEPTH];
  logic [CW-1:0] wr_ptr, rd_ptr, rx_count;
  logic          rx_pop_c, rx_is_full_c, rx_store_c;

  always_comb begin
    rx_pop_c     = reg_dat_re && (rx_count != '0);
    rx_is_full_c = (rx_count == FIFO_FULL);
    rx_store_c   = rx_push_c && (!rx_is_full_c || rx_pop_c);
    reg_dat_do   = (rx_count == '0) ? 32'hFFFF_FFFF : {24'h0, rx_mem[rd_ptr[AW-1:0]]};
  end

  always_ff @(posedge hw_clk) begin
    if (rx_store_c) rx_mem[wr_ptr[AW-1:0]] <= rx_byte;
  end

  always_ff @(posedge hw_clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rx_count   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_store_c) wr_ptr <= wr_ptr + CW'(1);
      if (rx_pop_c)   rd_ptr <= rd_ptr + CW'(1);
      if (rx_store_c && !rx_pop_c)
        rx_count <= rx_count + CW'(1);
      else if (!rx_store_c && rx_pop_c)
        rx_count <= rx_count - CW'(1);
      if (rx_push_c && rx_is_full_c && !rx_pop_c)
        rx_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_regif.sv
// Scoreboard bench for uart_regif: TX frames and register reads are checked
// by monitors against queues filled by the stimulus.
module tb_uart_regif;
  localparam int unsigned DIV      = 16;
  localparam int unsigned RX_DEPTH = 4;

  logic        hw_clk = 1'b0;
  logic        reset = 1'b1;
  logic        ser_rx = 1'b1;
  logic        reg_dat_we = 1'b0;
  logic        reg_dat_re = 1'b0;
  logic [31:0] reg_dat_di = 32'h0;
  logic        ser_tx;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;
  logic        rx_overrun;

  uart_regif #(.DIV(DIV), .RX_DEPTH(RX_DEPTH)) dut (
    .hw_clk      (hw_clk),
    .reset       (reset),
    .ser_tx      (ser_tx),
    .ser_rx      (ser_rx),
    .reg_dat_we  (reg_dat_we),
    .reg_dat_re  (reg_dat_re),
    .reg_dat_di  (reg_dat_di),
    .reg_dat_do  (reg_dat_do),
    .reg_dat_wait(reg_dat_wait),
    .rx_overrun  (rx_overrun)
  );

  always #5 hw_clk = ~hw_clk;

  int cyc = 0;
  always @(posedge hw_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [7:0]  tx_q [$];
  logic [31:0] rd_q [$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge hw_clk);
    #1;
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  // Drive frame bits LSB first, DIV cycles each, for ncyc cycles in total
  task automatic drive_bits(logic [9:0] fr, int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      ser_rx = fr[i / DIV];
      tick();
    end
  endtask

  task automatic send_rx(logic [7:0] b, logic stopb);
    drive_bits({stopb, b, 1'b0}, 10 * DIV);
  endtask

  task automatic read_exp(logic [31:0] e);
    rd_q.push_back(e);
    reg_dat_re = 1'b1;
    tick();
    reg_dat_re = 1'b0;
  endtask

  // Byte must appear 2 + DIV/2 + 9*DIV + 1 cycles after the line first goes low
  task automatic rx_with_latency(logic [7:0] b, string nm);
    int f0;
    int lat;
    f0  = cyc;
    lat = -1;
    fork
      send_rx(b, 1'b1);
      begin
        for (int k = 0; k < 300; k++) begin
          @(negedge hw_clk);
          if (reg_dat_do != 32'hFFFF_FFFF) begin
            lat = cyc - f0;
            break;
          end
        end
      end
    join
    check(nm, (lat >= 154 && lat <= 156) ? 32'd155 : 32'(lat), 32'd155);
  endtask

  // Read monitor: every cycle with a read strobe pops one expected value
  always @(negedge hw_clk) begin
    if (!reset && reg_dat_re) begin
      if (rd_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL rd_unexpected: got %h expected no read", reg_dat_do);
      end else begin
        check("rd_data", reg_dat_do, rd_q.pop_front());
      end
    end
  end

  // TX monitor: decode each frame and verify every bit is held DIV cycles
  logic [9:0] tx_bits;
  int         tx_bad;
  bit         tx_ab;
  initial begin
    forever begin
      @(negedge hw_clk);
      if (!reset && ser_tx === 1'b0) begin
        tx_bad = 0;
        tx_ab  = 1'b0;
        for (int i = 0; i < 10 * DIV; i++) begin
          if (i > 0) @(negedge hw_clk);
          if (reset) tx_ab = 1'b1;
          if (i % DIV == 0) tx_bits[i / DIV] = ser_tx;
          else if (ser_tx !== tx_bits[i / DIV]) tx_bad++;
        end
        if (!tx_ab) begin
          if (tx_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL tx_unexpected: got frame %h expected none", tx_bits);
          end else begin
            check("tx_byte", {24'h0, tx_bits[8:1]}, {24'h0, tx_q.pop_front()});
            check("tx_framing", {29'h0, tx_bad == 0, tx_bits[0], tx_bits[9]}, 32'h5);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int wcnt;
  initial begin
    ticks(3);
    reset = 1'b0;
    tick();
    check("rst_do", reg_dat_do, 32'hFFFF_FFFF);
    check("rst_ser_tx", {31'h0, ser_tx}, 32'h1);
    check("rst_wait", {31'h0, reg_dat_wait}, 32'h0);
    check("rst_overrun", {31'h0, rx_overrun}, 32'h0);
    read_exp(32'hFFFF_FFFF);
    check("empty_read_do", reg_dat_do, 32'hFFFF_FFFF);
    check("empty_read_tx", {31'h0, ser_tx}, 32'h1);

    // Single TX with a second write held through the frame
    reg_dat_di = 32'hABCD_EF50;
    reg_dat_we = 1'b1;
    tx_q.push_back(8'h50);
    tick();
    reg_dat_di = 32'h0000_0041;
    tx_q.push_back(8'h41);
    check("tx_start_bit", {31'h0, ser_tx}, 32'h0);
    wcnt = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge hw_clk);
      if (reg_dat_wait) wcnt++;
      else break;
    end
    check("tx_wait_cycles", 32'(wcnt), 32'd160);
    tick();
    reg_dat_we = 1'b0;
    check("tx_b2b_start", {31'h0, ser_tx}, 32'h0);
    ticks(10 * DIV + 20);
    check("tx_drain", 32'(tx_q.size()), 32'd0);
    check("tx_idle", {31'h0, ser_tx}, 32'h1);

    // Single RX
    rx_with_latency(8'h31, "rx_latency");
    ticks(5);
    read_exp(32'h0000_0031);
    read_exp(32'hFFFF_FFFF);

    // Overrun: five bytes into a four-entry FIFO
    for (int b = 8'h30; b <= 8'h34; b++) begin
      send_rx(8'(b), 1'b1);
      ticks(2);
    end
    ticks(10);
    check("overrun_set", {31'h0, rx_overrun}, 32'h1);
    read_exp(32'h30);
    read_exp(32'h31);
    read_exp(32'h32);
    read_exp(32'h33);
    read_exp(32'hFFFF_FFFF);
    check("overrun_sticky", {31'h0, rx_overrun}, 32'h1);

    // Line errors: glitch, framing error, line held low
    ser_rx = 1'b0;
    ticks(4);
    ser_rx = 1'b1;
    ticks(40);
    check("glitch_no_byte", reg_dat_do, 32'hFFFF_FFFF);
    send_rx(8'h55, 1'b0);
    ticks(100);
    check("framing_no_byte", reg_dat_do, 32'hFFFF_FFFF);
    ser_rx = 1'b1;
    ticks(40);
    check("hold_low_no_byte", reg_dat_do, 32'hFFFF_FFFF);
    rx_with_latency(8'h5A, "rx_after_err");
    ticks(5);
    read_exp(32'h5A);

    // Reset during RX data bit 3 with a byte queued and overrun set
    send_rx(8'h77, 1'b1);
    ticks(10);
    check("rx_pre_reset", reg_dat_do, 32'h77);
    drive_bits({1'b1, 8'h99, 1'b0}, 72);
    ser_rx = 1'b1;
    reset  = 1'b1;
    tick();
    check("rst_fifo_empty", reg_dat_do, 32'hFFFF_FFFF);
    check("rst_overrun_clr", {31'h0, rx_overrun}, 32'h0);
    reset = 1'b0;
    tick();
    rx_with_latency(8'hC3, "rx_after_reset");
    ticks(5);
    read_exp(32'hC3);
    read_exp(32'hFFFF_FFFF);

    // Reset during TX bit 4, then a clean frame
    reg_dat_di = 32'h3C;
    reg_dat_we = 1'b1;
    tick();
    reg_dat_we = 1'b0;
    ticks(4 * DIV + 5);
    reset = 1'b1;
    tick();
    check("rst_tx_idle", {31'h0, ser_tx}, 32'h1);
    reset = 1'b0;
    ticks(200);
    reg_dat_di = 32'h0D;
    tx_q.push_back(8'h0D);
    reg_dat_we = 1'b1;
    tick();
    reg_dat_we = 1'b0;
    ticks(10 * DIV + 20);
    check("tx_after_reset", 32'(tx_q.size()), 32'd0);
    check("rd_drain", 32'(rd_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
